// File: rtl/vp_key_event_tx.sv
// Key-event transmitter: turns PS/2 toggle-protocol keys and joystick numpad bits
// into queued ASCII press/release events, presented one at a time until acknowledged.
module vp_key_event_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joy_numpad,
    output logic        tx_data_ready_o,
    output logic [7:0]  tx_ascii_o,
    output logic        tx_released_o,
    input  logic        tx_read_i,
    output logic        overflow_o
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};

    // Returns {mapped, ascii}; the extended flag plays no part in the mapping.
    function automatic logic [8:0] ps2_to_ascii(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h16: r = {1'b1, 8'h31};  8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};  8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};  8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};  8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};  8'h45: r = {1'b1, 8'h30};
            8'h1C: r = {1'b1, 8'h61};  8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};  8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};  8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};  8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};  8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};  8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};  8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};  8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};  8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};  8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};  8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};  8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};  8'h1A: r = {1'b1, 8'h7A};
            8'h29: r = {1'b1, 8'h20};  8'h79: r = {1'b1, 8'h2B};
            8'h7B: r = {1'b1, 8'h2D};  8'h7C: r = {1'b1, 8'h2A};
            8'h4A: r = {1'b1, 8'h2F};  8'h55: r = {1'b1, 8'h3D};
            8'h1F: r = {1'b1, 8'h11};  8'h27: r = {1'b1, 8'h12};
            8'h5A: r = {1'b1, 8'h0A};  8'h66: r = {1'b1, 8'h08};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    logic              primed;
    logic              old_toggle;
    logic [9:0]        old_joy;
    logic [9:0]        pending;
    logic              ps2_evt;
    logic [7:0]        ps2_code;
    logic              ps2_rel;
    logic              push_req;
    logic [8:0]        push_data;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              unused_ext;

    logic [8:0]        ps2_map;
    logic              joy_any;
    logic [3:0]        joy_sel;
    logic [9:0]        svc_mask;
    logic [9:0]        pending_d;
    logic              push_req_d;
    logic [8:0]        push_data_d;
    logic              do_pop;
    logic              do_push;
    logic              drop;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [ADDR_W:0]   count_d;
    logic [8:0]        head_d;

    assign unused_ext = ps2_key[8];

    // Arbitration stage: a mapped PS/2 event wins; otherwise the lowest pending joystick bit.
    always_comb begin
        ps2_map     = ps2_to_ascii(ps2_code);
        joy_any     = |pending;
        joy_sel     = 4'd0;
        svc_mask    = 10'h000;
        push_req_d  = 1'b0;
        push_data_d = 9'h000;
        for (int i = 9; i >= 0; i--) begin
            if (pending[i]) joy_sel = 4'(i);
        end
        if (ps2_evt && ps2_map[8]) begin
            push_req_d  = 1'b1;
            push_data_d = {ps2_rel, ps2_map[7:0]};
        end else if (joy_any) begin
            push_req_d        = 1'b1;
            push_data_d[8]    = ~joy_numpad[joy_sel];
            push_data_d[7:0]  = (joy_sel == 4'd9) ? 8'h30 : 8'h31 + {4'h0, joy_sel};
            svc_mask[joy_sel] = 1'b1;
        end
        pending_d = (pending | (primed ? (joy_numpad ^ old_joy) : 10'h000)) & ~svc_mask;
    end

    // FIFO next state; the head is taken from the incoming entry when it lands at the new read slot.
    always_comb begin
        do_pop   = tx_read_i && tx_data_ready_o;
        do_push  = push_req && ((count != FULL_COUNT) || do_pop);
        drop     = push_req && (count == FULL_COUNT) && !do_pop;
        rd_ptr_d = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
        count_d  = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + COUNT_ONE;
            2'b01:   count_d = count - COUNT_ONE;
            default: count_d = count;
        endcase
        head_d = (do_push && (wr_ptr == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed          <= 1'b0;
            old_toggle      <= 1'b0;
            old_joy         <= 10'h000;
            pending         <= 10'h000;
            ps2_evt         <= 1'b0;
            ps2_code        <= 8'h00;
            ps2_rel         <= 1'b0;
            push_req        <= 1'b0;
            push_data       <= 9'h000;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tx_data_ready_o <= 1'b0;
            tx_ascii_o      <= 8'h00;
            tx_released_o   <= 1'b0;
            overflow_o      <= 1'b0;
        end else begin
            primed          <= 1'b1;
            old_toggle      <= ps2_key[10];
            old_joy         <= joy_numpad;
            pending         <= pending_d;
            ps2_evt         <= primed && (ps2_key[10] != old_toggle);
            ps2_code        <= ps2_key[7:0];
            ps2_rel         <= ~ps2_key[9];
            push_req        <= push_req_d;
            push_data       <= push_data_d;
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr          <= rd_ptr_d;
            count           <= count_d;
            tx_data_ready_o <= (count_d != '0);
            tx_released_o   <= head_d[8];
            tx_ascii_o      <= head_d[7:0];
            if (drop) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vp_key_event_tx.sv
// Directed bench for vp_key_event_tx: PS/2 and joystick events, arbitration,
// FIFO fill/overflow/drain, simultaneous push+pop when full, and reset flush.
module tb_vp_key_event_tx;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [9:0]  joy_numpad;
    logic        tx_data_ready_o;
    logic [7:0]  tx_ascii_o;
    logic        tx_released_o;
    logic        tx_read_i;
    logic        overflow_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                      8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] digit_codes  [9]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                      8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] joy_order    [6]  = '{8'h31, 8'h33, 8'h30, 8'h31, 8'h33, 8'h30};

    vp_key_event_tx #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ps2_key        (ps2_key),
        .joy_numpad     (joy_numpad),
        .tx_data_ready_o(tx_data_ready_o),
        .tx_ascii_o     (tx_ascii_o),
        .tx_released_o  (tx_released_o),
        .tx_read_i      (tx_read_i),
        .overflow_o     (overflow_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] ascii, input logic released);
        check_output({tag, "_ready"}, {7'h0, tx_data_ready_o}, 8'h01);
        check_output({tag, "_ascii"}, tx_ascii_o, ascii);
        check_output({tag, "_rel"}, {7'h0, tx_released_o}, {7'h0, released});
    endtask

    // Flips the toggle bit so the transmitter sees one new key event.
    task automatic apply_stimulus(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic ack_head();
        tx_read_i = 1'b1;
        tick();
        tx_read_i = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        ps2_key    = {1'b1, 10'h000};
        joy_numpad = 10'h001;
        tx_read_i  = 1'b0;
        tick();
        tick();
        check_output("rst_ready", {7'h0, tx_data_ready_o}, 8'h00);
        check_output("rst_ascii", tx_ascii_o, 8'h00);
        check_output("rst_rel", {7'h0, tx_released_o}, 8'h00);
        check_output("rst_ovf", {7'h0, overflow_o}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("prime_ready", {7'h0, tx_data_ready_o}, 8'h00);
        check_output("prime_ovf", {7'h0, overflow_o}, 8'h00);

        apply_stimulus(8'h1C, 1'b1);
        tick();
        apply_stimulus(8'h1C, 1'b0);
        check_output("a_lat0", {7'h0, tx_data_ready_o}, 8'h00);
        tick();
        check_output("a_lat1", {7'h0, tx_data_ready_o}, 8'h00);
        tick();
        check_head("a_press", 8'h61, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_head("a_press_held", 8'h61, 1'b0);
        ack_head();
        check_head("a_release", 8'h61, 1'b1);
        ack_head();
        check_output("a_drained", {7'h0, tx_data_ready_o}, 8'h00);

        joy_numpad = 10'h000;
        for (int i = 0; i < 4; i++) tick();
        check_head("joy1_rel", 8'h31, 1'b1);
        ack_head();
        check_output("joy1_drained", {7'h0, tx_data_ready_o}, 8'h00);

        joy_numpad = 10'h205;
        tick();
        tick();
        check_output("joy_lat1", {7'h0, tx_data_ready_o}, 8'h00);
        tick();
        check_head("joy_first", 8'h31, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        joy_numpad = 10'h000;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 6; i++) begin
            check_head($sformatf("joy_q%0d", i), joy_order[i], (i >= 3));
            ack_head();
        end
        check_output("joy_drained", {7'h0, tx_data_ready_o}, 8'h00);

        apply_stimulus(8'h76, 1'b1);
        joy_numpad = 10'h010;
        tick();
        tick();
        check_output("unm_lat1", {7'h0, tx_data_ready_o}, 8'h00);
        tick();
        check_head("unm_joy5", 8'h35, 1'b0);
        check_output("unm_ovf", {7'h0, overflow_o}, 8'h00);
        ack_head();
        for (int i = 0; i < 3; i++) tick();
        check_output("unm_count1", {7'h0, tx_data_ready_o}, 8'h00);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(letter_codes[i], 1'b1);
            tick();
        end
        check_output("fill_no_ovf_yet", {7'h0, overflow_o}, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        check_output("fill_ovf", {7'h0, overflow_o}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("fill_q%0d", i), 8'h61 + 8'(i), 1'b0);
            ack_head();
        end
        check_output("fill_drained", {7'h0, tx_data_ready_o}, 8'h00);
        check_output("fill_ovf_sticky", {7'h0, overflow_o}, 8'h01);

        apply_stimulus(8'h1C, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check_output("flush_pre", {7'h0, tx_data_ready_o}, 8'h01);
        reset = 1'b1;
        tick();
        check_output("flush_ready", {7'h0, tx_data_ready_o}, 8'h00);
        check_output("flush_ovf", {7'h0, overflow_o}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("reprime_ready", {7'h0, tx_data_ready_o}, 8'h00);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(digit_codes[i], 1'b1);
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        check_head("full_head", 8'h31, 1'b0);
        check_output("full_no_ovf", {7'h0, overflow_o}, 8'h00);
        apply_stimulus(digit_codes[8], 1'b1);
        tick();
        tick();
        ack_head();
        check_output("pushpop_ovf", {7'h0, overflow_o}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("pp_q%0d", i), 8'h32 + 8'(i), 1'b0);
            ack_head();
        end
        check_output("pp_drained", {7'h0, tx_data_ready_o}, 8'h00);
        check_output("pp_final_ovf", {7'h0, overflow_o}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
